// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
//   Request/result bundle for the bit-serial subtractor.
//   master : requester side (drives start/a/b/bin, observes busy/done/diff/bout)
//   slave  : subtractor side (the inverse)
//   Signals:
//     start  request pulse, sampled only while the subtractor is idle
//     a, b   minuend / subtrahend, WIDTH bits
//     bin    borrow-in
//     busy   high while bits are being shifted through
//     done   one-cycle completion pulse
//     diff   registered (a - b - bin) mod 2^WIDTH
//     bout   final borrow-out
interface serial_subtractor_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bout
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bout
   );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor computing a - b - bin, LSB first, one bit
//   per clock, with a registered borrow. Operands are captured on an accepted
//   start; the result is published together with a one-cycle done pulse and
//   then held until the next completion or reset.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  serial_subtractor_if.slave (start/a/b/bin in, busy/done/diff/bout out)
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input logic                 clk,
   input logic                 rst,
   serial_subtractor_if.slave  bus
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state;
   state_t           state_next;

   logic [WIDTH-1:0] areg;
   logic [WIDTH-1:0] breg;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] sres;
   logic [WIDTH-1:0] diff_q;
   logic [CW-1:0]    cnt;
   logic             brw;
   logic             brw_next;
   logic             bout_q;
   logic             d;
   logic             last;
   logic             a0;
   logic             b0;

   // One full-subtractor cell working on the current LSBs.
   always_comb begin
      a0       = areg[0];
      b0       = breg[0];
      d        = a0 ^ b0 ^ brw;
      brw_next = (~a0 & b0) | (~(a0 ^ b0) & brw);
      // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
      sres     = {d, sreg[WIDTH-1:1]};
      last     = (cnt == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start) state_next = SHIFT;
         SHIFT:   if (last)      state_next = DONE;
         DONE:                   state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         areg   <= '0;
         breg   <= '0;
         sreg   <= '0;
         cnt    <= '0;
         brw    <= 1'b0;
         diff_q <= '0;
         bout_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  areg <= bus.a;
                  breg <= bus.b;
                  brw  <= bus.bin;
                  cnt  <= '0;
                  sreg <= '0;
               end
            end
            SHIFT: begin
               areg <= {1'b0, areg[WIDTH-1:1]};
               breg <= {1'b0, breg[WIDTH-1:1]};
               brw  <= brw_next;
               sreg <= sres;
               cnt  <= cnt + CW'(1);
               // Publish on the WIDTH-th bit; outputs never see partial results.
               if (last) begin
                  diff_q <= sres;
                  bout_q <= brw_next;
               end
            end
            default: ;
         endcase
      end
   end

   // busy/done decode directly from the state register, so they are glitch-free,
   // mutually exclusive, and drop immediately on reset.
   assign bus.busy = (state == SHIFT);
   assign bus.done = (state == DONE);
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor (WIDTH=8): a directed vector
//   table plus hand-written sequences for ignored start, asynchronous reset
//   mid-operation and back-to-back operation with start held high.
module tb_serial_subtractor;

   localparam int unsigned W = 8;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   serial_subtractor_if #(.WIDTH(W)) bus ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      logic [W-1:0] exp_diff;
      logic         exp_bout;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one operation from IDLE and check latency, busy span and result.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input logic [W-1:0] exp_diff, input logic exp_bout);
      int lat;
      int busy_cnt;
      @(negedge clk);
      bus.a     = a;
      bus.b     = b;
      bus.bin   = bin;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a     = ~a;
      bus.b     = ~b;
      bus.bin   = ~bin;
      lat       = 0;
      busy_cnt  = (bus.busy === 1'b1) ? 1 : 0;
      for (int i = 1; i <= int'(W) + 4; i++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) begin
            lat = i;
            break;
         end
         if (bus.busy === 1'b1) busy_cnt++;
      end
      chk("latency", lat, W);
      chk("busy_cycles", busy_cnt, W);
      chk("diff", bus.diff, exp_diff);
      chk("bout", bus.bout, exp_bout);
      @(posedge clk);
      #1;
      chk("done_width", bus.done, 1'b0);
   endtask

   vec_t vecs[8];

   initial begin
      int dones;
      int since;
      int cyc;
      logic [W-1:0] ca, cb;
      logic         cbin;
      logic [W:0]   ref_full;
      logic [W-1:0] got_diff;

      checks    = 0;
      failures  = 0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.bin   = 1'b0;

      vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
      vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
      vecs[2] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
      vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[4] = '{8'h10, 8'h00, 1'b1, 8'h0F, 1'b0};
      vecs[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
      vecs[6] = '{8'hC8, 8'h64, 1'b0, 8'h64, 1'b0};
      vecs[7] = '{8'h01, 8'hFF, 1'b0, 8'h02, 1'b1};

      // Reset state.
      rst = 1'b1;
      #12;
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_diff", bus.diff, 8'h00);
      chk("rst_bout", bus.bout, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      // Reset pulse while idle.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_busy", bus.busy, 1'b0);

      // Directed vector table.
      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp_diff, vecs[i].exp_bout);
      end

      // Second start during SHIFT is ignored; exactly one done pulse.
      @(negedge clk);
      bus.a = 8'h33; bus.b = 8'h11; bus.bin = 1'b0; bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      bus.a = 8'hAA; bus.b = 8'h01; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      dones    = 0;
      got_diff = '0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) begin
            dones++;
            got_diff = bus.diff;
            chk("ign_bout", bus.bout, 1'b0);
         end
      end
      chk("ign_done_count", dones, 1);
      chk("ign_diff", got_diff, 8'h22);

      // Asynchronous reset after 4 shift cycles.
      @(negedge clk);
      bus.a = 8'hF0; bus.b = 8'h0F; bus.bin = 1'b0; bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_busy", bus.busy, 1'b0);
      chk("arst_done", bus.done, 1'b0);
      chk("arst_diff", bus.diff, 8'h00);
      chk("arst_bout", bus.bout, 1'b0);
      @(negedge clk);
      rst   = 1'b0;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) dones++;
      end
      chk("arst_no_done", dones, 0);
      run_op(8'h09, 8'h04, 1'b0, 8'h05, 1'b0);

      // Back-to-back with start held high, random operands vs arithmetic model.
      @(negedge clk);
      ca = W'($urandom); cb = W'($urandom); cbin = 1'($urandom);
      bus.a = ca; bus.b = cb; bus.bin = cbin; bus.start = 1'b1;
      dones = 0;
      since = 0;
      cyc   = 0;
      while (dones < 100 && cyc < 100 * (W + 2) + 50) begin
         @(posedge clk);
         #1;
         cyc++;
         since++;
         if (bus.busy === 1'b1 && bus.done === 1'b1) chk("busy_and_done", 1, 0);
         if (bus.done === 1'b1) begin
            ref_full = {1'b0, ca} - {1'b0, cb} - {{W{1'b0}}, cbin};
            chk("b2b_diff", bus.diff, ref_full[W-1:0]);
            chk("b2b_bout", bus.bout, ref_full[W]);
            if (dones > 0) chk("b2b_period", since, W + 2);
            since = 0;
            dones++;
            ca = W'($urandom); cb = W'($urandom); cbin = 1'($urandom);
            bus.a = ca; bus.b = cb; bus.bin = cbin;
         end
      end
      chk("b2b_done_total", dones, 100);
      bus.start = 1'b0;
      repeat (W + 4) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
